// File: rtl/adder_subtractor_bist_ctrl.sv
// -----------------------------------------------------------------------------
// adder_subtractor_bist_ctrl
//
// Built-in self-test sequencer for the 8-bit adder_subtractor_net datapath.
// A 17-bit Fibonacci LFSR (x^17 + x^14 + 1) produces one {a, b, sub} vector per
// APPLY cycle. The 9-bit combinational result is folded into a 16-bit MISR
// (x^16 + x^12 + x^5 + 1). After N_PATTERNS vectors the signature is compared
// against golden_sig, and pass/done are reported to the test-mode controller.
//
// Optional build macro: BIST_SEED_LOAD_EN
//   When defined, a seed_in[16:0] port is added. LOAD uses seed_in when it is
//   nonzero, otherwise the SEED parameter. When undefined, LOAD always uses
//   SEED and there is no seed_in port.
//
// Parameters:
//   N_PATTERNS  vectors applied per run, 1..131071
//   SEED        LFSR load value at run start, must be nonzero
//
// Ports:
//   clk         clock, rising edge
//   rst_n       asynchronous active-low reset
//   start       run request, honoured in IDLE or DONE
//   abort       cancel run, FSM returns to IDLE on the next edge
//   golden_sig  expected MISR signature, sampled in COMPARE
//   seed_in     (BIST_SEED_LOAD_EN only) run-time LFSR seed, sampled in LOAD
//   a, b        datapath operands, bit 0 is the MSB
//   sub         datapath subtract select
//   result      datapath result, bit 0 is carry/borrow, bit 8 is the LSB
//   busy        high in LOAD, APPLY and COMPARE
//   done        high in DONE
//   pass        signature match, meaningful while done = 1
//   misr_sig    current MISR contents
//   state_dbg   current FSM state encoding (debug observation only)
//
// Handshake: start is a level sampled on each rising edge while the FSM is in
// IDLE or DONE; a run is accepted on the first such edge with start=1 and
// abort=0. abort has priority over start in every state. done/pass form a
// level-valid pair: pass is only meaningful while done is high, and both hold
// until the next accepted start or an abort.
// -----------------------------------------------------------------------------
module adder_subtractor_bist_ctrl #(
    parameter int          N_PATTERNS = 256,
    parameter logic [16:0] SEED       = 17'h1ACE1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        abort,
    input  logic [15:0] golden_sig,
`ifdef BIST_SEED_LOAD_EN
    input  logic [16:0] seed_in,
`endif
    output logic [0:7]  a,
    output logic [0:7]  b,
    output logic        sub,
    input  logic [0:8]  result,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [15:0] misr_sig,
    output logic [2:0]  state_dbg
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LOAD    = 3'd1,
        S_APPLY   = 3'd2,
        S_COMPARE = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    // The counter must hold N_PATTERNS itself (value after the last APPLY
    // edge), so it never wraps inside a run.
    localparam int            CW       = $clog2(N_PATTERNS + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(N_PATTERNS - 1);

    localparam logic [15:0] MISR_POLY = 16'h1021;

    state_t        state_q, state_d;
    logic [16:0]   lfsr_q,  lfsr_d;
    logic [15:0]   misr_q,  misr_d;
    logic [CW-1:0] cnt_q,   cnt_d;
    logic          pass_q,  pass_d;

    logic [16:0]   load_seed;
    logic [16:0]   lfsr_step;
    logic [15:0]   misr_step;
    logic [15:0]   misr_fb;
    logic [15:0]   misr_data;

    // ------------------------------------------------------------------
    // Seed selection for the LOAD cycle
    // ------------------------------------------------------------------
`ifdef BIST_SEED_LOAD_EN
    // A zero seed would lock the LFSR at zero, so fall back to SEED.
    assign load_seed = (seed_in != 17'd0) ? seed_in : SEED;
`else
    assign load_seed = SEED;
`endif

    // ------------------------------------------------------------------
    // Pattern generator and signature compactor step functions
    // ------------------------------------------------------------------
    assign lfsr_step = {lfsr_q[15:0], lfsr_q[16] ^ lfsr_q[13]};

    // result is declared [0:8]; as a packed value result[0] is its MSB, so
    // zero-extending it places result[8] at bit 0 of the injected word.
    assign misr_fb   = misr_q[15] ? MISR_POLY : 16'h0000;
    assign misr_data = {7'b0, result};
    assign misr_step = {misr_q[14:0], 1'b0} ^ misr_fb ^ misr_data;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            lfsr_q  <= 17'd0;
            misr_q  <= 16'd0;
            cnt_q   <= '0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            lfsr_q  <= lfsr_d;
            misr_q  <= misr_d;
            cnt_q   <= cnt_d;
            pass_q  <= pass_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and datapath register update
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        lfsr_d  = lfsr_q;
        misr_d  = misr_q;
        cnt_d   = cnt_q;
        pass_d  = pass_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d = S_LOAD;
                    pass_d  = 1'b0;
                end
            end

            S_LOAD: begin
                lfsr_d  = load_seed;
                misr_d  = 16'd0;
                cnt_d   = '0;
                state_d = S_APPLY;
            end

            S_APPLY: begin
                misr_d = misr_step;
                lfsr_d = lfsr_step;
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    state_d = S_COMPARE;
                end
            end

            S_COMPARE: begin
                pass_d  = (misr_q == golden_sig);
                state_d = S_DONE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        // abort overrides everything, including a simultaneous start. The
        // LFSR and MISR are frozen rather than cleared so the point of
        // interruption can still be inspected; LOAD reinitialises them.
        if (abort) begin
            state_d = S_IDLE;
            pass_d  = 1'b0;
            lfsr_d  = lfsr_q;
            misr_d  = misr_q;
            cnt_d   = cnt_q;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    // Operands are gated so the datapath sees all-zero inputs outside APPLY.
    // a/b are declared [0:7], so lfsr[16] lands on a[0] (the MSB).
    always_comb begin
        a   = 8'h00;
        b   = 8'h00;
        sub = 1'b0;
        if (state_q == S_APPLY) begin
            a   = lfsr_q[16:9];
            b   = lfsr_q[8:1];
            sub = lfsr_q[0];
        end
    end

    assign busy      = (state_q == S_LOAD) || (state_q == S_APPLY) ||
                       (state_q == S_COMPARE);
    assign done      = (state_q == S_DONE);
    assign pass      = pass_q;
    assign misr_sig  = misr_q;
    assign state_dbg = state_q;

endmodule

// File: doc/adder_subtractor_bist_ctrl.md
Name: adder_subtractor_bist_ctrl

Overview:
- Built-in self-test sequencer for the 8-bit adder_subtractor_net datapath, which is purely combinational.
- Generates pseudo-random {a, b, sub} vectors with a 17-bit LFSR and drives them into the datapath.
- Compacts the 9-bit result stream into a 16-bit MISR and compares the final signature against a golden value.
- Sits between the test-mode controller (start/abort/done/pass handshake) and the datapath's input/output pins.

Parameters:
- N_PATTERNS, 256, number of vectors applied per run; legal range 1..131071.
- SEED, 17'h1ACE1, LFSR load value at run start; must be nonzero.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  run request, sampled in IDLE or DONE.
- abort  input  1  cancel run, returns FSM to IDLE.
- golden_sig  input  16  expected MISR signature, sampled in COMPARE.
- a  output  [0:7]  datapath operand A; bit 0 is MSB.
- b  output  [0:7]  datapath operand B; bit 0 is MSB.
- sub  output  1  datapath subtract select.
- result  input  [0:8]  datapath result; bit 0 is carry/borrow, bit 8 is LSB.
- busy  output  1  high in LOAD, APPLY and COMPARE.
- done  output  1  high in DONE.
- pass  output  1  signature match, valid while done=1.
- misr_sig  output  16  current MISR contents.

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE, lfsr=0, misr=0, cnt=0, busy=0, done=0, pass=0, a=0, b=0, sub=0.
- FSM states: IDLE, LOAD, APPLY, COMPARE, DONE.
- IDLE/DONE: start=1 and abort=0 -> LOAD; done and pass clear on that edge.
- LOAD (1 cycle): lfsr<=SEED, misr<=0, cnt<=0 -> APPLY.
- APPLY (exactly N_PATTERNS cycles):
  - Pattern decode: a[0..7]=lfsr[16..9], b[0..7]=lfsr[8..1], sub=lfsr[0].
  - Each edge: misr<=next(misr, result), lfsr advances, cnt+1.
  - After the edge with cnt=N_PATTERNS-1 -> COMPARE.
- LFSR: Fibonacci, polynomial x^17+x^14+1. lfsr<={lfsr[15:0], lfsr[16]^lfsr[13]}. Maximal length; never reaches 0 from a nonzero seed.
- MISR: polynomial x^16+x^12+x^5+1.
  - Feedback term f = misr[15] ? 16'h1021 : 0.
  - Data injection d = {7'b0, result[0], ..., result[8]}, with result[8] at bit 0.
  - misr_next = {misr[14:0],1'b0} ^ f ^ d.
- Outputs a, b, sub are 0 outside APPLY; the datapath result is ignored outside APPLY.
- COMPARE (1 cycle): pass<=(misr==golden_sig) -> DONE.
- DONE: done=1; pass, misr_sig and state hold until start or abort.
- Latency: done rises N_PATTERNS+2 cycles after the edge that samples start.
- abort=1 in any state -> IDLE on the next edge.
  - Clears done and pass.
  - Preserves misr and lfsr for debug; they are reinitialised in LOAD.
  - abort and start asserted together: abort wins.
- start while busy=1 is ignored.
- cnt width is $clog2(N_PATTERNS+1); no wrap occurs inside a run.
- Reset mid-run: immediate return to the reset values, no partial done.

Optional Feature:
- Macro: BIST_SEED_LOAD_EN.
- When defined:
  - Adds input seed_in [16:0].
  - LOAD uses seed_in if nonzero, otherwise SEED; seed_in is sampled in the LOAD cycle.
- When undefined:
  - No seed_in port.
  - LOAD always uses SEED.

Test Plan:
1. N_PATTERNS=4, SEED=17'h00001, start pulse -> APPLY vectors {a,b,sub} = 00001, 00002, 00004, 00008 hex; done rises exactly 6 cycles after the start sample edge; busy high for 6 cycles.
2. N_PATTERNS=256, fault-free datapath, golden_sig from the bench behavioural model -> done=1, pass=1, misr_sig==golden_sig.
3. Same run with golden_sig XOR 16'h0001 -> done=1, pass=0; result[4] forced stuck-at-0 with the correct golden -> pass=0.
4. abort asserted at cycle 10 of APPLY -> next edge state IDLE, busy=0, done=0, a=b=0, sub=0; a following start gives the same misr_sig as an uninterrupted run.
5. start asserted together with abort in IDLE -> stays in IDLE; start re-pulsed during APPLY -> run length unchanged.
6. rst_n low mid-APPLY -> all outputs 0 asynchronously; after release, a full run passes. With BIST_SEED_LOAD_EN and seed_in=17'h00001 -> the first vector is 00001 regardless of SEED.
